shift_add_mult_ctrl: RTL
========================

SHIFT_ADD_MULT_CTRL -- requirements
Module: shift_add_mult_ctrl

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8: operand width N.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request a multiply; sampled only in IDLE.
REQ-005 SHALL have port multiplicand, input, N: operand M, captured when start is accepted.
REQ-006 SHALL have port multiplier, input, N: operand Q, parallel-loaded into the downstream right shift register.
REQ-007 SHALL have port sr_q, input, N: current contents of the downstream right shift register.
REQ-008 SHALL have port sr_en, output, 1: enable for the downstream right shift register.
REQ-009 SHALL have port sr_shift_load, output, 1: 1 means shift, 0 means load.
REQ-010 SHALL have port sr_d, output, N: parallel-load data for the shift register.
REQ-011 SHALL have port sr_d_shift, output, 1: serial bit entering the shift register MSB on a shift.
REQ-012 SHALL have port busy, output, 1: high in RUN and DONE.
REQ-013 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-014 SHALL have port product, output, 2N: registered unsigned result.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DONE, plus an N-bit accumulator A, registered multiplicand M, and a cycle counter cnt of width clog2(N+1).
REQ-016 SHALL, in IDLE with start=1, drive combinationally sr_en=1, sr_shift_load=0 and sr_d=multiplier.
REQ-017 SHALL, on the same edge as REQ-016, capture M, clear A and cnt, and move to RUN.
REQ-018 SHALL, in IDLE with start=0, drive sr_en=0, sr_shift_load=0, sr_d=0 and sr_d_shift=0.
REQ-019 SHALL, in RUN, compute sum = {1'b0,A} + (sr_q[0] ? M : 0) as N+1 bits, so the carry is never lost.
REQ-020 SHALL, in RUN, drive sr_en=1, sr_shift_load=1 and sr_d_shift=sum[0].
REQ-021 SHALL, on each RUN edge, set A<=sum[N:1] and cnt<=cnt+1.
REQ-022 SHALL, on the RUN edge where cnt==N-1, set product<={sum[N:1], sum[0], sr_q[N-1:1]} and move to DONE; RUN therefore lasts exactly N cycles.
REQ-023 SHALL, in DONE, assert done=1 and sr_en=0, then return to IDLE on the next edge; done is high for exactly one cycle.
REQ-024 SHALL have latency from start accepted at edge 0 to done high in the cycle after edge N, i.e. N+1 cycles.
REQ-025 SHALL ignore start in RUN and DONE; a start in DONE is lost, and start is accepted again in the first IDLE cycle, so back-to-back operations run every N+2 cycles.
REQ-026 SHALL hold product stable from its update until the next operation's final RUN edge.
REQ-027 SHALL not sample multiplicand or multiplier changes after acceptance.
REQ-028 SHALL produce an unsigned result only; no overflow is possible because the full 2N width is kept.

Reset
REQ-029 SHALL, on rst=1, immediately force state=IDLE, A=0, M=0, cnt=0 and product=0, which drives done=0, busy=0 and sr_en=0.
REQ-030 SHALL, on rst asserted mid-RUN, abort the operation with no done pulse; the downstream register's contents are then don't-care.
REQ-031 SHALL, after rst deasserts, accept start on the first rising edge.

Verification
REQ-032 SHALL cover N=8, 13x11 -> done 9 cycles after start, product=0x008F.
REQ-033 SHALL cover N=8, 255x255 -> product=0xFE01, exercising carry into sum[N].
REQ-034 SHALL cover N=8, 0x5A x 0 and 0 x 0xFF -> product=0x0000, with done still after 9 cycles.
REQ-035 SHALL cover start pulsed in RUN cycle 3 and in DONE -> ignored; single done pulse; product of the first operands only.
REQ-036 SHALL cover rst in RUN cycle 4 of 200x3 -> busy=0 and product=0 immediately, no done; a following 7x6 gives 0x002A.
REQ-037 SHALL cover start held high continuously -> operations every 10 cycles, each done exactly one cycle wide.

Source files
------------

// File: rtl/shift_add_mult_ctrl.sv
// Control and accumulator for an unsigned shift-add multiplier. The multiplier
// operand lives in an external right shift register that this block loads and shifts.
module shift_add_mult_ctrl #(
    parameter int DATA_SIZE = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [DATA_SIZE-1:0]     multiplicand,
    input  logic [DATA_SIZE-1:0]     multiplier,
    input  logic [DATA_SIZE-1:0]     sr_q,
    output logic                     sr_en,
    output logic                     sr_shift_load,
    output logic [DATA_SIZE-1:0]     sr_d,
    output logic                     sr_d_shift,
    output logic                     busy,
    output logic                     done,
    output logic [2*DATA_SIZE-1:0]   product
);
    localparam int CW = $clog2(DATA_SIZE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state_q;
    logic [DATA_SIZE-1:0]     a_q;
    logic [DATA_SIZE-1:0]     m_q;
    logic [CW-1:0]            cnt_q;
    logic [2*DATA_SIZE-1:0]   product_q;
    logic [DATA_SIZE:0]       sum_d;
    logic                     last_d;

    // One extra bit keeps the carry of A + M; its LSB is the product bit retired this cycle.
    assign sum_d  = {1'b0, a_q} + (sr_q[0] ? {1'b0, m_q} : '0);
    assign last_d = (cnt_q == CW'(DATA_SIZE - 1));

    always_comb begin
        sr_en         = 1'b0;
        sr_shift_load = 1'b0;
        sr_d          = '0;
        sr_d_shift    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_en = 1'b1;
                    sr_d  = multiplier;
                end
            end
            RUN: begin
                sr_en         = 1'b1;
                sr_shift_load = 1'b1;
                sr_d_shift    = sum_d[0];
            end
            default: ;
        endcase
    end

    assign busy    = (state_q == RUN) || (state_q == DONE);
    assign done    = (state_q == DONE);
    assign product = product_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            m_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        m_q     <= multiplicand;
                        a_q     <= '0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= sum_d[DATA_SIZE:1];
                    cnt_q <= cnt_q + CW'(1);
                    // Final step: upper half from the new A, lower half from the shifted register.
                    if (last_d) begin
                        product_q <= {sum_d, sr_q[DATA_SIZE-1:1]};
                        state_q   <= DONE;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
